// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display/CPU VRAM arbiter; macro VRAM_BLANK_ONLY_EN limits CPU access to blanking
module vram_arbiter #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_wait,
    input  logic          blanking,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        C_IDLE,
        C_ISSUE,
        C_CAP,
        C_ACK,
        C_HOLD
    } cpu_state_t;

    cpu_state_t    r_state;
    cpu_state_t    w_next;
    logic          w_grant;
    logic          w_cpu_elig;

    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_wdata;
    logic          r_disp_p1;
    logic          r_disp_p2;
    logic          r_disp_valid;
    logic [DW-1:0] r_disp_data;
    logic [DW-1:0] r_cpu_rdata;

`ifdef VRAM_BLANK_ONLY_EN
    assign w_cpu_elig = blanking;
`else
    // blanking does not gate the CPU in this build; any display-free cycle is usable
    assign w_cpu_elig = blanking | 1'b1;
`endif

    // CPU handshake state register
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // CPU next-state and grant decision; the display always takes the slot first
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (cpu_req && !disp_req && w_cpu_elig) begin
                    w_grant = 1'b1;
                    w_next  = C_ISSUE;
                end
            end
            // r_ram_we is high in C_ISSUE exactly when the granted access was a write
            C_ISSUE: w_next = r_ram_we ? C_ACK : C_CAP;
            C_CAP:   w_next = C_ACK;
            C_ACK:   w_next = C_HOLD;
            C_HOLD:  w_next = cpu_req ? C_HOLD : C_IDLE;
            default: w_next = C_IDLE;
        endcase
    end

    // SRAM issue slot, display read pipeline and CPU read capture
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_disp_p1    <= 1'b0;
            r_disp_p2    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (disp_req) begin
                r_ram_addr <= disp_addr;
            end else if (w_grant) begin
                r_ram_addr  <= cpu_addr;
                r_ram_we    <= cpu_we;
                r_ram_wdata <= cpu_wdata;
            end
            // address edge k, SRAM samples at k+1, data captured at k+2
            r_disp_p1    <= disp_req;
            r_disp_p2    <= r_disp_p1;
            r_disp_valid <= r_disp_p2;
            if (r_disp_p2) begin
                r_disp_data <= ram_rdata;
            end
            // a display fetch issued during C_ISSUE only reaches ram_rdata one cycle later
            if (r_state == C_CAP) begin
                r_cpu_rdata <= ram_rdata;
            end
        end
    end

    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ack    = (r_state == C_ACK);
    assign cpu_wait   = cpu_req && (r_state != C_ACK);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait;
    logic        blanking;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int we_cnt = 0;
    int dv_cnt = 0;

    logic [7:0] mem [0:8191];

    vram_arbiter #(.AW(13), .DW(8)) dut (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .disp_req(disp_req),
        .disp_addr(disp_addr),
        .disp_data(disp_data),
        .disp_valid(disp_valid),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack),
        .cpu_wait(cpu_wait),
        .blanking(blanking),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 pixel_clock = ~pixel_clock;

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ 8'h3C ^ {3'b000, a[12:8]};
    endfunction

    // synchronous SRAM: read data valid the cycle after the address edge
    always @(posedge pixel_clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge pixel_clock) begin
        if (cpu_ack) ack_cnt++;
        if (ram_we) we_cnt++;
        if (disp_valid) dv_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge pixel_clock);
        #1;
    endtask

    // one CPU access; cycles counts sampled cycles from request up to and including the ack cycle
    task automatic cpu_txn(input logic we, input logic [12:0] a, input logic [7:0] wd, input logic bl,
                           output int cycles, output logic wait_at_ack);
        cycles = 0;
        wait_at_ack = 1'b1;
        step();
        blanking = bl;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        for (int n = 0; n < 60; n++) begin
            @(negedge pixel_clock);
            cycles++;
            if (cpu_ack) begin
                wait_at_ack = cpu_wait;
                break;
            end
            step();
        end
        step();
        cpu_req = 1'b0;
        step();
        step();
    endtask

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic        blank;
        logic [7:0]  exp_rdata;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int cyc;
        logic wt;
        int a0, w0, d0;

        for (int i = 0; i < 8192; i++) mem[i] = pat(i[12:0]);

        vecs[0] = '{1'b1, 13'h0123, 8'h5A, 1'b1, 8'h00, 3};
        vecs[1] = '{1'b0, 13'h0123, 8'h00, 1'b1, 8'h5A, 4};
        vecs[2] = '{1'b0, 13'h0040, 8'h00, 1'b0, 8'h7C, 4};
        vecs[3] = '{1'b1, 13'h1FFF, 8'hC3, 1'b0, 8'h00, 3};
        vecs[4] = '{1'b0, 13'h1FFF, 8'h00, 1'b1, 8'hC3, 4};
        vecs[5] = '{1'b0, 13'h1FFE, 8'h00, 1'b0, 8'hDD, 4};
        vecs[6] = '{1'b1, 13'h0000, 8'hFF, 1'b1, 8'h00, 3};
        vecs[7] = '{1'b0, 13'h0000, 8'h00, 1'b0, 8'hFF, 4};
        vecs[8] = '{1'b0, 13'h0001, 8'h00, 1'b1, 8'h3D, 4};

        reset = 1'b1;
        disp_req = 1'b0;
        disp_addr = '0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        blanking = 1'b1;

        // reset state
        @(negedge pixel_clock);
        cpu_req = 1'b1;
        #1;
        check("rst_outputs", {ram_addr, ram_we, ram_wdata, disp_data, disp_valid, cpu_rdata, cpu_ack}, 32'h0);
        check("rst_wait_follows_req", cpu_wait, 1'b1);
        cpu_req = 1'b0;
        #1;
        check("rst_wait_low", cpu_wait, 1'b0);
        step();
        reset = 1'b0;
        step();

        // table-driven CPU accesses
        for (int i = 0; i < 9; i++) begin
            logic bl;
            w0 = we_cnt;
`ifdef VRAM_BLANK_ONLY_EN
            bl = 1'b1;
`else
            bl = vecs[i].blank;
`endif
            cpu_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, bl, cyc, wt);
            check($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_cycles);
            check($sformatf("vec%0d_wait_at_ack", i), wt, 1'b0);
            check($sformatf("vec%0d_we_pulses", i), we_cnt - w0, {31'b0, vecs[i].we});
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
        end

        // collision: display and CPU on the same edge, display wins
        blanking = 1'b1;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 13'h0010;
        disp_req = 1'b1;
        disp_addr = 13'h0020;
        step();
        disp_req = 1'b0;
        @(negedge pixel_clock);
        check("coll_first_addr", ram_addr, 13'h0020);
        step();
        @(negedge pixel_clock);
        check("coll_second_addr", ram_addr, 13'h0010);
        step();
        @(negedge pixel_clock);
        check("coll_disp_valid", disp_valid, 1'b1);
        check("coll_disp_data", disp_data, 8'h1C);
        step();
        @(negedge pixel_clock);
        check("coll_cpu_ack", cpu_ack, 1'b1);
        check("coll_cpu_rdata", cpu_rdata, 8'h2C);
        check("coll_disp_valid_drop", disp_valid, 1'b0);
        step();
        cpu_req = 1'b0;
        step();
        step();

        // display burst with CPU read held throughout
        a0 = ack_cnt; w0 = we_cnt; d0 = dv_cnt;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 13'h0055;
        for (int i = 0; i < 64; i++) begin
            logic [12:0] da;
            da = 13'h0100 + 13'(i * 37);
            disp_req = 1'b1;
            disp_addr = da;
            step();
            disp_req = 1'b0;
            @(negedge pixel_clock);
            check($sformatf("burst%0d_addr", i), {ram_we, ram_addr}, {1'b0, da});
            step();
            step();
            @(negedge pixel_clock);
            check($sformatf("burst%0d_valid_data", i), {disp_valid, disp_data}, {1'b1, pat(da)});
            step();
        end
        cpu_req = 1'b0;
        step();
        step();
        check("burst_dv_count", dv_cnt - d0, 64);
        check("burst_ack_count", ack_cnt - a0, 1);
        check("burst_we_count", we_cnt - w0, 0);
        check("burst_cpu_rdata", cpu_rdata, 8'h69);

        // reset while the CPU read sits in C_CAP with a display fetch in flight
        a0 = ack_cnt; w0 = we_cnt; d0 = dv_cnt;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 13'h0300;
        step();
        disp_req = 1'b1;
        disp_addr = 13'h0301;
        step();
        disp_req = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {ram_addr, ram_we, ram_wdata, disp_data, disp_valid, cpu_rdata, cpu_ack}, 32'h0);
        check("midrst_wait", cpu_wait, 1'b1);
        step();
        cpu_req = 1'b0;
        step();
        reset = 1'b0;
        repeat (6) step();
        check("midrst_no_ack", ack_cnt - a0, 0);
        check("midrst_no_dv", dv_cnt - d0, 0);
        check("midrst_no_we", we_cnt - w0, 0);
        cpu_txn(1'b0, 13'h0300, 8'h00, 1'b1, cyc, wt);
        check("postrst_latency", cyc, 4);
        check("postrst_rdata", cpu_rdata, 8'h3F);

        // held request: one access, one ack
        a0 = ack_cnt; w0 = we_cnt;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 13'h0700;
        cpu_wdata = 8'h11;
        cyc = 0;
        while (!cpu_ack && cyc < 60) begin
            @(negedge pixel_clock);
            cyc++;
            if (!cpu_ack) step();
        end
        check("held_ack_seen", cpu_ack, 1'b1);
        repeat (11) step();
        cpu_req = 1'b0;
        step();
        step();
        check("held_ack_count", ack_cnt - a0, 1);
        check("held_we_count", we_cnt - w0, 1);
        cpu_txn(1'b0, 13'h0700, 8'h00, 1'b1, cyc, wt);
        check("held_readback", cpu_rdata, 8'h11);

`ifdef VRAM_BLANK_ONLY_EN
        // blank gating: a write waits out active video
        a0 = ack_cnt; w0 = we_cnt;
        blanking = 1'b0;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 13'h0800;
        cpu_wdata = 8'hA7;
        repeat (200) step();
        @(negedge pixel_clock);
        check("blank_no_we", we_cnt - w0, 0);
        check("blank_wait_high", cpu_wait, 1'b1);
        check("blank_no_ack", ack_cnt - a0, 0);
        step();
        blanking = 1'b1;
        cyc = 0;
        while (!cpu_ack && cyc < 60) begin
            @(negedge pixel_clock);
            cyc++;
            if (!cpu_ack) step();
        end
        step();
        cpu_req = 1'b0;
        repeat (3) step();
        check("blank_ack_once", ack_cnt - a0, 1);
        check("blank_we_once", we_cnt - w0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
